// File: rtl/nios2_cpu_mult_unit.sv
// nios2_cpu_mult_unit: two-stage pipelined DATA_W x DATA_W multiplier returning the
// low (mul) or high (mulxuu/mulxsu/mulxss) product half, with en stall and flush.
module nios2_cpu_mult_unit #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);
  localparam int NS = DATA_W / SLICE_W;
  localparam int PW = 2 * SLICE_W;
  localparam int FW = 2 * DATA_W;
  logic [NS*NS-1:0][PW-1:0] pp_q, pp_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0] op_q, op_d;
  logic v1_q, v1_d, corr_a_q, corr_a_d, corr_b_q, corr_b_d, out_valid_q, out_valid_d;
  logic [FW-1:0] prod;
  always_comb begin
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++)
        pp_d[i*NS+j] = en ? PW'(src_a[i*SLICE_W +: SLICE_W]) * PW'(src_b[j*SLICE_W +: SLICE_W])
                          : pp_q[i*NS+j];
    a_d      = en ? src_a : a_q;
    b_d      = en ? src_b : b_q;
    op_d     = en ? op : op_q;
    corr_a_d = en ? (op[1] & src_a[DATA_W-1]) : corr_a_q;
    corr_b_d = en ? (&op & src_b[DATA_W-1]) : corr_b_q;
    v1_d     = flush ? 1'b0 : (en ? in_valid : v1_q);
    prod = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++)
        prod = prod + (FW'(pp_q[i*NS+j]) << ((i + j) * SLICE_W));
    // Signed operands: subtract the other operand weighted by 2^DATA_W for each set sign bit
    prod = prod - {({DATA_W{corr_a_q}} & b_q), {DATA_W{1'b0}}};
    prod = prod - {({DATA_W{corr_b_q}} & a_q), {DATA_W{1'b0}}};
    result_d    = en ? ((op_q == 2'b00) ? prod[DATA_W-1:0] : prod[FW-1:DATA_W]) : result_q;
    out_valid_d = flush ? 1'b0 : (en ? v1_q : out_valid_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      corr_a_q    <= 1'b0;
      corr_b_q    <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      pp_q        <= pp_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      corr_a_q    <= corr_a_d;
      corr_b_q    <= corr_b_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule
